// File: rtl/dm_ctrl.sv
// Data-memory access unit behind the MEM stage: wait-stated word RAM with byte lanes,
// load extension, misalignment detection and a pipeline stall while an access is in flight.
module dm_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        done,
    output logic        stall,
    output logic        misalign
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W+1:0] addr;
        logic [31:0]       data;
        logic [2:0]        typ;
    } dm_req_t;

    state_t  state, state_n;
    logic [3:0] cnt, cnt_n;
    logic    commit, latch;
    dm_req_t cur, acc;
    logic    mis_q;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    logic unused_addr;
    assign unused_addr = ^Addr_in[31:ADDR_W+2];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        latch   = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE: if (req) begin
                stall = 1'b1;
                latch = 1'b1;
                if (WAIT_CYCLES == 0) begin
                    commit  = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n   = WAIT_CYCLES[3:0];
                    state_n = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    commit  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Zero-wait builds commit straight from the port values, so decode from whichever is live.
    always_comb begin
        acc = cur;
        if (latch) begin
            acc.we   = mem_w;
            acc.addr = Addr_in[ADDR_W+1:0];
            acc.data = Data_in;
            acc.typ  = DMType;
        end
    end

    logic is_half, is_byte, is_word, mis;
    logic [ADDR_W-1:0] idx;
    logic [31:0] rd, ld;
    logic [15:0] hsel;
    logic [7:0]  bsel;
    logic [NUM_LANES-1:0]      lane_en;
    logic [NUM_LANES-1:0][7:0] wdata;

    assign is_half = (acc.typ == 3'b001) || (acc.typ == 3'b010);
    assign is_byte = (acc.typ == 3'b011) || (acc.typ == 3'b100);
    assign is_word = !is_half && !is_byte;
    assign mis     = (is_word && acc.addr[1:0] != 2'b00) || (is_half && acc.addr[0]);
    assign idx     = acc.addr[ADDR_W+1:2];
    assign rd      = mem[idx];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LANE = 2'(i);
        assign lane_en[i] = is_word || (is_half && acc.addr[1] == LANE[1]) ||
                            (is_byte && acc.addr[1:0] == LANE);
        assign wdata[i]   = is_word ? acc.data[8*i +: 8] :
                            is_half ? acc.data[8*(i%2) +: 8] : acc.data[7:0];
    end

    always_comb begin
        hsel = acc.addr[1] ? rd[31:16] : rd[15:0];
        bsel = rd[8*acc.addr[1:0] +: 8];
        case (acc.typ)
            3'b001:  ld = {{16{hsel[15]}}, hsel};
            3'b010:  ld = {16'h0, hsel};
            3'b011:  ld = {{24{bsel[7]}}, bsel};
            3'b100:  ld = {24'h0, bsel};
            default: ld = rd;
        endcase
    end

    // RAM contents survive reset; reset only blocks a commit on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && commit && acc.we && !mis) begin
            for (int i = 0; i < NUM_LANES; i++)
                if (lane_en[i]) mem[idx][8*i +: 8] <= wdata[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            cur      <= '0;
            Data_out <= 32'h0;
            mis_q    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (latch) cur <= acc;
            if (commit) begin
                Data_out <= (acc.we || mis) ? 32'h0 : ld;
                mis_q    <= mis;
            end
        end
    end

    assign done     = (state == RESP);
    assign misalign = done && mis_q;
endmodule
